// File: rtl/operand_fetch_stage_if.sv
// Instruction-in / operands-out handshake bundle of the operand-fetch stage.
// The master is the decode side; the slave is the operand-fetch stage itself.
interface operand_fetch_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TAG_W  = 16
) ();
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rs1;
   logic [ADDR_W-1:0] in_rs2;
   logic [ADDR_W-1:0] in_rd;
   logic [TAG_W-1:0]  in_tag;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_tag, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_rd, out_tag
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_tag, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_rd, out_tag
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Two-stage operand fetch: S1 drives register-file read addresses, S2 holds resolved
// operands, forwarding any write-back the register file cannot yet show.
module operand_fetch_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TAG_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   operand_fetch_stage_if.slave bus,
   output logic [ADDR_W-1:0]    rf_read1,
   output logic [ADDR_W-1:0]    rf_read2,
   input  logic [DATA_W-1:0]    rf_data1,
   input  logic [DATA_W-1:0]    rf_data2,
   input  logic                 wb_enable,
   input  logic [ADDR_W-1:0]    wb_reg,
   input  logic [DATA_W-1:0]    wb_data
);

   function automatic logic wb_hit(input logic en, input logic [ADDR_W-1:0] wreg,
                                   input logic [ADDR_W-1:0] a);
      return en && (wreg != {ADDR_W{1'b0}}) && (wreg == a);
   endfunction

   // Operand priority: r0, write landing now, write that landed on the RF sample edge, RF data.
   function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] rs,
                                                 input logic hit_now, input logic [DATA_W-1:0] wdata,
                                                 input logic byp_en, input logic [DATA_W-1:0] byp_data,
                                                 input logic [DATA_W-1:0] rf_data);
      if (rs == {ADDR_W{1'b0}})
         return {DATA_W{1'b0}};
      else if (hit_now)
         return wdata;
      else if (byp_en)
         return byp_data;
      else
         return rf_data;
   endfunction

   logic              advance_s;
   logic              s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d, s1_rd_q, s1_rd_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_rd_q, out_rd_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic [DATA_W-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
   logic              byp1_en_q, byp1_en_d, byp2_en_q, byp2_en_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;

   assign advance_s     = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = advance_s;
   // A stalled S1 keeps re-reading its own sources so rf_data stays current for it.
   assign rf_read1      = advance_s ? bus.in_rs1 : s1_rs1_q;
   assign rf_read2      = advance_s ? bus.in_rs2 : s1_rs2_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_op1   = out_op1_q;
   assign bus.out_op2   = out_op2_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_tag   = out_tag_q;

   // Next-state for both pipeline stages and the same-edge bypass registers.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_rs1_d    = s1_rs1_q;
      s1_rs2_d    = s1_rs2_q;
      s1_rd_d     = s1_rd_q;
      s1_tag_d    = s1_tag_q;
      out_valid_d = out_valid_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_rd_d    = out_rd_q;
      out_tag_d   = out_tag_q;
      out_op1_d   = out_op1_q;
      out_op2_d   = out_op2_q;
      byp1_en_d   = wb_hit(wb_enable, wb_reg, rf_read1);
      byp2_en_d   = wb_hit(wb_enable, wb_reg, rf_read2);
      byp_data_d  = wb_data;
      if (advance_s) begin
         s1_valid_d  = bus.in_valid;
         s1_rs1_d    = bus.in_rs1;
         s1_rs2_d    = bus.in_rs2;
         s1_rd_d     = bus.in_rd;
         s1_tag_d    = bus.in_tag;
         out_valid_d = s1_valid_q;
         out_rs1_d   = s1_rs1_q;
         out_rs2_d   = s1_rs2_q;
         out_rd_d    = s1_rd_q;
         out_tag_d   = s1_tag_q;
         out_op1_d   = resolve(s1_rs1_q, wb_hit(wb_enable, wb_reg, s1_rs1_q), wb_data,
                               byp1_en_q, byp_data_q, rf_data1);
         out_op2_d   = resolve(s1_rs2_q, wb_hit(wb_enable, wb_reg, s1_rs2_q), wb_data,
                               byp2_en_q, byp_data_q, rf_data2);
      end else begin
         // Held operands keep absorbing writes; only older instructions can produce them.
         if (wb_hit(wb_enable, wb_reg, out_rs1_q))
            out_op1_d = wb_data;
         else
            out_op1_d = out_op1_q;
         if (wb_hit(wb_enable, wb_reg, out_rs2_q))
            out_op2_d = wb_data;
         else
            out_op2_d = out_op2_q;
      end
   end

   // State registers with synchronous reset discarding in-flight instructions.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_rs1_q    <= {ADDR_W{1'b0}};
         s1_rs2_q    <= {ADDR_W{1'b0}};
         s1_rd_q     <= {ADDR_W{1'b0}};
         s1_tag_q    <= {TAG_W{1'b0}};
         out_valid_q <= 1'b0;
         out_rs1_q   <= {ADDR_W{1'b0}};
         out_rs2_q   <= {ADDR_W{1'b0}};
         out_rd_q    <= {ADDR_W{1'b0}};
         out_tag_q   <= {TAG_W{1'b0}};
         out_op1_q   <= {DATA_W{1'b0}};
         out_op2_q   <= {DATA_W{1'b0}};
         byp1_en_q   <= 1'b0;
         byp2_en_q   <= 1'b0;
         byp_data_q  <= {DATA_W{1'b0}};
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_rs1_q    <= s1_rs1_d;
         s1_rs2_q    <= s1_rs2_d;
         s1_rd_q     <= s1_rd_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_rs1_q   <= out_rs1_d;
         out_rs2_q   <= out_rs2_d;
         out_rd_q    <= out_rd_d;
         out_tag_q   <= out_tag_d;
         out_op1_q   <= out_op1_d;
         out_op2_q   <= out_op2_d;
         byp1_en_q   <= byp1_en_d;
         byp2_en_q   <= byp2_en_d;
         byp_data_q  <= byp_data_d;
      end
   end

endmodule
